// File: rtl/audio_i2s_tx.sv
// I2S transmitter: 2-entry {L,R} frame FIFO, BCLK/LRCK generation, MSB-first serial data.
// Define AUDIO_TX_HOLD_EN to repeat the last frame on underrun; otherwise silence is sent.
module audio_i2s_tx #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4
) (
  input  logic                     AUDIO_CLK,
  input  logic                     reset_n,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     sample_strobe,
  input  logic                     clear_flags,
  output logic                     aud_bclk,
  output logic                     aud_daclrck,
  output logic                     aud_dacdat,
  output logic                     frame_start,
  output logic [1:0]               fifo_level,
  output logic                     overrun,
  output logic                     underrun
);

  localparam int FW    = 2 * SLOT_BITS;
  localparam int EW    = 2 * AUD_BIT_DEPTH;
  localparam int PAD   = SLOT_BITS - AUD_BIT_DEPTH;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BC_W  = $clog2(FW);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FW - 1);
  localparam logic [BC_W-1:0]  BC_SLOT  = BC_W'(SLOT_BITS);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [FW-1:0]    r_fs;
  logic [EW-1:0]    r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;

  logic             w_wrap;
  logic             w_fall;
  logic             w_boundary;
  logic             w_pop_ok;
  logic             w_pop_empty;
  logic             w_push_ok;
  logic             w_push_drop;
  logic [BC_W-1:0]  w_bit_next;
  logic [EW-1:0]    w_head;
  logic [FW-1:0]    w_head_frame;
  logic [FW-1:0]    w_empty_frame;
  logic [FW-1:0]    w_reload;

  assign w_wrap      = (r_div_cnt == DIV_LAST);
  assign w_fall      = w_wrap & aud_bclk;
  assign w_boundary  = w_fall & (r_bit_cnt == BC_LAST);
  assign w_pop_ok    = w_boundary & (fifo_level != 2'd0);
  assign w_pop_empty = w_boundary & (fifo_level == 2'd0);
  // The pop is resolved first, so a full FIFO still accepts a push in the pop cycle.
  assign w_push_ok   = sample_strobe & ((fifo_level != 2'd2) | w_pop_ok);
  assign w_push_drop = sample_strobe & ~w_push_ok;
  assign w_bit_next  = (r_bit_cnt == BC_LAST) ? '0 : r_bit_cnt + 1'b1;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_frame = (FW'(w_head[EW-1:AUD_BIT_DEPTH]) << (FW - AUD_BIT_DEPTH))
                      | (FW'(w_head[AUD_BIT_DEPTH-1:0]) << PAD);

`ifdef AUDIO_TX_HOLD_EN
  logic [FW-1:0] r_last;

  always_ff @(posedge AUDIO_CLK) begin
    if (!reset_n) begin
      r_last <= '0;
    end else if (w_pop_ok) begin
      r_last <= w_head_frame;
    end
  end

  assign w_empty_frame = r_last;
`else
  assign w_empty_frame = '0;
`endif

  assign w_reload = w_pop_ok ? w_head_frame : w_empty_frame;

  always_ff @(posedge AUDIO_CLK) begin
    if (!reset_n) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_fs        <= '0;
      aud_bclk    <= 1'b0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_div_cnt   <= w_wrap ? '0 : r_div_cnt + 1'b1;
      frame_start <= w_boundary;
      if (w_wrap) begin
        aud_bclk <= ~aud_bclk;
      end
      if (w_fall) begin
        r_bit_cnt   <= w_bit_next;
        aud_daclrck <= (w_bit_next >= BC_SLOT);
        aud_dacdat  <= r_fs[FW-1];
        r_fs        <= w_boundary ? w_reload : {r_fs[FW-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (!reset_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      fifo_level <= 2'd0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {lsound_in, rsound_in};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   fifo_level <= fifo_level + 2'd1;
        2'b01:   fifo_level <= fifo_level - 2'd1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A set event in the same cycle beats clear_flags.
  always_ff @(posedge AUDIO_CLK) begin
    if (!reset_n) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= w_push_drop | (overrun & ~clear_flags);
      underrun <= w_pop_empty | (underrun & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx; the reference model tracks the frame queue and
// derives every output from the cycle count since reset release.
module tb_audio_i2s_tx;

  localparam int AUD  = 24;
  localparam int SLOT = 32;
  localparam int DIV  = 4;
  localparam int FW   = 2 * SLOT;
  localparam int FCYC = 2 * DIV * FW;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] lsound_in;
  logic [23:0] rsound_in;
  logic        sample_strobe;
  logic        clear_flags;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        frame_start;
  logic [1:0]  fifo_level;
  logic        overrun;
  logic        underrun;

  audio_i2s_tx #(.AUD_BIT_DEPTH(AUD), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
    .AUDIO_CLK     (clk),
    .reset_n       (reset_n),
    .lsound_in     (lsound_in),
    .rsound_in     (rsound_in),
    .sample_strobe (sample_strobe),
    .clear_flags   (clear_flags),
    .aud_bclk      (aud_bclk),
    .aud_daclrck   (aud_daclrck),
    .aud_dacdat    (aud_dacdat),
    .frame_start   (frame_start),
    .fifo_level    (fifo_level),
    .overrun       (overrun),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          k;
  logic [47:0] q[$];
  logic [63:0] cur_frame;
  logic [63:0] last_frame;
  logic        m_bclk, m_lrck, m_dat, m_fs, m_over, m_under;

  function automatic logic [63:0] mkframe(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  task automatic model_reset();
    k = 0;
    q.delete();
    cur_frame  = '0;
    last_frame = '0;
    m_bclk = 0; m_lrck = 0; m_dat = 0; m_fs = 0; m_over = 0; m_under = 0;
  endtask

  task automatic do_reset(input int cyc);
    reset_n = 1'b0;
    sample_strobe = 1'b0;
    clear_flags = 1'b0;
    lsound_in = '0;
    rsound_in = '0;
    repeat (cyc) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, advance the model for the coming edge, sample at the negedge.
  task automatic tick(input logic strobe, input logic [23:0] l, input logic [23:0] r,
                      input logic clr);
    int n;
    logic [47:0] e;
    logic set_o, set_u;
    sample_strobe = strobe;
    lsound_in = l;
    rsound_in = r;
    clear_flags = clr;
    k++;
    set_o = 0;
    set_u = 0;
    m_fs = 0;
    if (k % (2 * DIV) == 0) begin
      n = k / (2 * DIV);
      m_dat  = cur_frame[FW - 1 - ((n - 1) % FW)];
      m_lrck = ((n % FW) >= SLOT);
      if (n % FW == 0) begin
        m_fs = 1;
        if (q.size() > 0) begin
          e = q.pop_front();
          cur_frame  = mkframe(e[47:24], e[23:0]);
          last_frame = cur_frame;
        end else begin
          set_u = 1;
`ifdef AUDIO_TX_HOLD_EN
          cur_frame = last_frame;
`else
          cur_frame = '0;
`endif
        end
      end
    end
    if (strobe) begin
      if (q.size() < 2) q.push_back({l, r});
      else set_o = 1;
    end
    m_over  = set_o | (m_over & ~clr);
    m_under = set_u | (m_under & ~clr);
    m_bclk  = ((k / DIV) % 2) == 1;
    @(posedge clk);
    @(negedge clk);
    sample_strobe = 1'b0;
    clear_flags = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_b, exp_l;
    do_reset(5);
    n_tests++;
    if ({aud_bclk, aud_daclrck, aud_dacdat, frame_start, fifo_level, overrun, underrun} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {aud_bclk, aud_daclrck, aud_dacdat, frame_start, fifo_level, overrun, underrun});
    end
    for (int i = 1; i <= 3 * FCYC / 2; i++) begin
      tick(0, 0, 0, 0);
      exp_b = ((i / DIV) % 2) == 1;
      exp_l = ((i / (2 * DIV)) % FW) >= SLOT;
      n_tests++;
      if (aud_bclk !== exp_b) begin
        n_fail++;
        $display("FAIL bclk_timing k=%0d got=%b exp=%b", i, aud_bclk, exp_b);
      end
      n_tests++;
      if (aud_daclrck !== exp_l) begin
        n_fail++;
        $display("FAIL lrck_timing k=%0d got=%b exp=%b", i, aud_daclrck, exp_l);
      end
      n_tests++;
      if (frame_start !== (i % FCYC == 0)) begin
        n_fail++;
        $display("FAIL frame_start_timing k=%0d got=%b exp=%b", i, frame_start, (i % FCYC == 0));
      end
    end
  endtask

  task automatic test_single_frame();
    int b;
    logic exp;
    do_reset(2);
    repeat (9) tick(0, 0, 0, 0);
    tick(1, 24'h800001, 24'h7FFFFE, 0);
    n_tests++;
    if (fifo_level !== 2'd1) begin
      n_fail++;
      $display("FAIL single_level got=%0d exp=1", fifo_level);
    end
    while (k < 2 * FCYC - 1) begin
      tick(0, 0, 0, 0);
      if (k > FCYC && k % (2 * DIV) == 0) begin
        b = k / (2 * DIV) - FW;
        exp = (b == 1 || b == 24 || (b >= 34 && b <= 55));
        n_tests++;
        if (aud_dacdat !== exp) begin
          n_fail++;
          $display("FAIL single_dacdat bit_cnt=%0d got=%b exp=%b", b, aud_dacdat, exp);
        end
      end
    end
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL single_underrun got=%b exp=0", underrun);
    end
  endtask

  // continues directly from test_single_frame: FIFO is now empty
  task automatic test_underrun();
    int b;
    logic exp;
    tick(0, 0, 0, 0);
    n_tests++;
    if (underrun !== 1'b1 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_set got=%b/%b exp=1/1", underrun, frame_start);
    end
    while (k < 3 * FCYC - 1) begin
      tick(0, 0, 0, 0);
      if (k % (2 * DIV) == 0) begin
        b = k / (2 * DIV) - 2 * FW;
`ifdef AUDIO_TX_HOLD_EN
        exp = (b == 1 || b == 24 || (b >= 34 && b <= 55));
`else
        exp = 1'b0;
`endif
        n_tests++;
        if (aud_dacdat !== exp) begin
          n_fail++;
          $display("FAIL underrun_dacdat bit_cnt=%0d got=%b exp=%b", b, aud_dacdat, exp);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [23:0] sl[3];
    logic [23:0] sr[3];
    logic [63:0] got1, got2;
    int n;
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      sl[i] = 24'($urandom());
      sr[i] = 24'($urandom());
    end
    for (int i = 0; i < 3; i++) begin
      repeat (19) tick(0, 0, 0, 0);
      tick(1, sl[i], sr[i], 0);
      n_tests++;
      if (fifo_level !== ((i == 0) ? 2'd1 : 2'd2)) begin
        n_fail++;
        $display("FAIL overrun_level push=%0d got=%0d exp=%0d", i, fifo_level, (i == 0) ? 1 : 2);
      end
      n_tests++;
      if (overrun !== (i == 2)) begin
        n_fail++;
        $display("FAIL overrun_flag push=%0d got=%b exp=%b", i, overrun, (i == 2));
      end
    end
    tick(0, 0, 0, 1);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear got=%b exp=0", overrun);
    end
    got1 = '0;
    got2 = '0;
    while (k < 3 * FCYC) begin
      tick(0, 0, 0, 0);
      if (k % (2 * DIV) == 0) begin
        n = k / (2 * DIV);
        if (n > FW && n <= 2 * FW) got1[2 * FW - n] = aud_dacdat;
        if (n > 2 * FW && n <= 3 * FW) got2[3 * FW - n] = aud_dacdat;
      end
    end
    n_tests++;
    if (got1 !== mkframe(sl[0], sr[0])) begin
      n_fail++;
      $display("FAIL overrun_frame1 got=%h exp=%h", got1, mkframe(sl[0], sr[0]));
    end
    n_tests++;
    if (got2 !== mkframe(sl[1], sr[1])) begin
      n_fail++;
      $display("FAIL overrun_frame2 got=%h exp=%h", got2, mkframe(sl[1], sr[1]));
    end
  endtask

  task automatic test_simultaneous();
    do_reset(2);
    repeat (9) tick(0, 0, 0, 0);
    tick(1, 24'($urandom()), 24'($urandom()), 0);
    repeat (9) tick(0, 0, 0, 0);
    tick(1, 24'($urandom()), 24'($urandom()), 0);
    while (k < FCYC - 1) tick(0, 0, 0, 0);
    tick(1, 24'($urandom()), 24'($urandom()), 0);
    n_tests++;
    if (fifo_level !== 2'd2 || overrun !== 1'b0 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_full level/over/fs got=%0d/%b/%b exp=2/0/1", fifo_level, overrun, frame_start);
    end
    while (k < 4 * FCYC - 1) tick(0, 0, 0, 0);
    n_tests++;
    if (fifo_level !== 2'd0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_drained level/under got=%0d/%b exp=0/0", fifo_level, underrun);
    end
    tick(1, 24'($urandom()), 24'($urandom()), 1);
    n_tests++;
    if (fifo_level !== 2'd1 || underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_empty level/under got=%0d/%b exp=1/1", fifo_level, underrun);
    end
    while (k < 5 * FCYC) begin
      tick(0, 0, 0, 0);
      n_tests++;
      if (aud_dacdat !== m_dat) begin
        n_fail++;
        $display("FAIL sim_dacdat k=%0d got=%b exp=%b", k, aud_dacdat, m_dat);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    do_reset(2);
    repeat (9) tick(0, 0, 0, 0);
    tick(1, 24'($urandom()), 24'($urandom()), 0);
    repeat (9) tick(0, 0, 0, 0);
    tick(1, 24'($urandom()), 24'($urandom()), 0);
    while (k < 599) tick(0, 0, 0, 0);
    tick(1, 24'($urandom()), 24'($urandom()), 0);
    while (k < FCYC + 40 * 2 * DIV) tick(0, 0, 0, 0);
    n_tests++;
    if (fifo_level !== 2'd2) begin
      n_fail++;
      $display("FAIL midreset_pre_level got=%0d exp=2", fifo_level);
    end
    do_reset(1);
    n_tests++;
    if ({aud_bclk, aud_daclrck, aud_dacdat, frame_start, fifo_level, overrun, underrun} !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%b exp=00000000",
               {aud_bclk, aud_daclrck, aud_dacdat, frame_start, fifo_level, overrun, underrun});
    end
    while (k < 2 * FCYC) begin
      tick(0, 0, 0, 0);
      n_tests++;
      if (aud_dacdat !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_dacdat k=%0d got=%b exp=0", k, aud_dacdat);
      end
    end
  endtask

  task automatic test_random_stream();
    logic st, cl;
    int rate;
    do_reset(3);
    for (int i = 0; i < 6 * FCYC; i++) begin
      rate = ((i / FCYC) % 3 == 0) ? 30 : ((i / FCYC) % 3 == 1) ? 3 : 0;
      st = ($urandom_range(0, 999) < rate);
      cl = ($urandom_range(0, 299) == 0);
      tick(st, 24'($urandom()), 24'($urandom()), cl);
      n_tests++;
      if ({aud_bclk, aud_daclrck, aud_dacdat, frame_start, fifo_level, overrun, underrun}
          !== {m_bclk, m_lrck, m_dat, m_fs, 2'(q.size()), m_over, m_under}) begin
        n_fail++;
        $display("FAIL random_outputs k=%0d got=%b exp=%b", k,
                 {aud_bclk, aud_daclrck, aud_dacdat, frame_start, fifo_level, overrun, underrun},
                 {m_bclk, m_lrck, m_dat, m_fs, 2'(q.size()), m_over, m_under});
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sample_strobe = 1'b0;
    clear_flags = 1'b0;
    lsound_in = '0;
    rsound_in = '0;
    model_reset();
    test_reset();
    test_single_frame();
    test_underrun();
    test_overrun();
    test_simultaneous();
    test_mid_frame_reset();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
